// File: rtl/visitor_pkg.sv
// Shared constants and index helpers for the visitor feeder and the neighborhood glue.
// State encoding stays as plain localparams so legacy logic can compare raw codes.
package visitor_pkg;

  localparam int NUM_TOWNS_DEF = 4;
  localparam int OBJ_ADDR_LEN  = 12;
  localparam int M10K_ADDR_LEN = 10;
  localparam int TOWN_W        = OBJ_ADDR_LEN - M10K_ADDR_LEN;
  localparam int DATA_W        = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PRIME  = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // The owning town is simply the index bits above the per-town body address.
  function automatic logic [TOWN_W-1:0] town_of(input logic [OBJ_ADDR_LEN-1:0] index);
    town_of = index[OBJ_ADDR_LEN-1:M10K_ADDR_LEN];
  endfunction

  function automatic logic [M10K_ADDR_LEN-1:0] rel_index_of(input logic [OBJ_ADDR_LEN-1:0] index);
    rel_index_of = index[M10K_ADDR_LEN-1:0];
  endfunction

endpackage

// File: rtl/m10k.sv
// Simple dual-port block RAM: port a reads with one cycle latency, port b writes.
// Read-during-write to the same address returns the old contents.
module m10k #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] address_a,
  output logic [DATA_W-1:0] q_a,
  input  logic [ADDR_W-1:0] address_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wren_b
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Storage carries no reset so table contents survive a design reset.
  always_ff @(posedge clk) begin
    if (wren_b) begin
      mem_q[address_b] <= data_b;
    end
    q_a <= mem_q[address_a];
  end

endmodule

// File: rtl/visitor_center.sv
// Global visitor table and broadcast sequencer feeding every neighborhood block.
// One visitor is presented at a time; the stream moves on only when all towns ask for more.
module visitor_center
  import visitor_pkg::*;
#(
  parameter int NUM_TOWNS        = NUM_TOWNS_DEF,
  parameter int obj_address_len  = OBJ_ADDR_LEN,
  parameter int m10k_address_len = M10K_ADDR_LEN
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [obj_address_len-1:0]  i_number_of_visitors,
  input  logic [NUM_TOWNS-1:0]        i_next,
  input  logic [obj_address_len-1:0]  i_vis_write_addr,
  input  logic                        i_vis_we,
  input  logic [31:0]                 i_x_write_data,
  input  logic [31:0]                 i_y_write_data,
  input  logic [31:0]                 i_mass_write_data,
  output logic [31:0]                 o_visitor_x_pos,
  output logic [31:0]                 o_visitor_y_pos,
  output logic [31:0]                 o_visitor_mass,
  output logic [NUM_TOWNS-1:0]        o_relative_visitor_valid,
  output logic [m10k_address_len-1:0] o_relative_visitor_index,
  output logic                        o_last_visitor,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [obj_address_len-1:0]  o_visitor_index
);

  localparam int AW = obj_address_len;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        count_q, count_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic [AW-1:0]        index_q, index_d;
  logic [31:0]          x_q, x_d, y_q, y_d, m_q, m_d;
  logic [NUM_TOWNS-1:0] valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [31:0]          x_rd_s, y_rd_s, m_rd_s;
  logic                 advance_s, hps_we_s, at_last_s, rd_more_s;
  logic [AW-1:0]        last_idx_s, index_inc_s, rd_inc_s;

  function automatic logic [NUM_TOWNS-1:0] town_onehot(input logic [AW-1:0] idx);
    for (int t = 0; t < NUM_TOWNS; t++) begin
      town_onehot[t] = (town_of(idx) == TOWN_W'(t));
    end
  endfunction

  assign advance_s   = &i_next;
  assign last_idx_s  = count_q - AW'(1);
  assign at_last_s   = (index_q == last_idx_s);
  assign rd_more_s   = (rd_addr_q < last_idx_s);
  assign index_inc_s = index_q + AW'(1);
  assign rd_inc_s    = rd_more_s ? (rd_addr_q + AW'(1)) : rd_addr_q;
  assign hps_we_s    = i_vis_we && ((state_q == IDLE) || (state_q == DONE));

  // The RAM is addressed with the next read pointer so its output is already the prefetched entry.
  m10k #(.DATA_W(32), .ADDR_W(AW)) u_x_tbl (
    .clk(i_clk), .address_a(rd_addr_d), .q_a(x_rd_s),
    .address_b(i_vis_write_addr), .data_b(i_x_write_data), .wren_b(hps_we_s)
  );
  m10k #(.DATA_W(32), .ADDR_W(AW)) u_y_tbl (
    .clk(i_clk), .address_a(rd_addr_d), .q_a(y_rd_s),
    .address_b(i_vis_write_addr), .data_b(i_y_write_data), .wren_b(hps_we_s)
  );
  m10k #(.DATA_W(32), .ADDR_W(AW)) u_m_tbl (
    .clk(i_clk), .address_a(rd_addr_d), .q_a(m_rd_s),
    .address_b(i_vis_write_addr), .data_b(i_mass_write_data), .wren_b(hps_we_s)
  );

  // Sequencer next-state and output-register next values.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_addr_d = rd_addr_q;
    index_d   = index_q;
    x_d       = x_q;
    y_d       = y_q;
    m_d       = m_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          count_d = i_number_of_visitors;
          valid_d = {NUM_TOWNS{1'b0}};
          last_d  = 1'b0;
          if (i_number_of_visitors == {AW{1'b0}}) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d   = PRIME;
            rd_addr_d = {AW{1'b0}};
            busy_d    = 1'b1;
            done_d    = 1'b0;
          end
        end else begin
          state_d = state_q;
        end
      end
      PRIME: begin
        state_d   = STREAM;
        index_d   = {AW{1'b0}};
        x_d       = x_rd_s;
        y_d       = y_rd_s;
        m_d       = m_rd_s;
        valid_d   = town_onehot({AW{1'b0}});
        last_d    = (last_idx_s == {AW{1'b0}});
        rd_addr_d = rd_inc_s;
      end
      STREAM: begin
        if (!advance_s) begin
          state_d = STREAM;
        end else if (at_last_s) begin
          state_d = DONE;
          valid_d = {NUM_TOWNS{1'b0}};
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          index_d   = index_inc_s;
          x_d       = x_rd_s;
          y_d       = y_rd_s;
          m_d       = m_rd_s;
          valid_d   = town_onehot(index_inc_s);
          last_d    = (index_inc_s == last_idx_s);
          rd_addr_d = rd_inc_s;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = {NUM_TOWNS{1'b0}};
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      count_q   <= {AW{1'b0}};
      rd_addr_q <= {AW{1'b0}};
      index_q   <= {AW{1'b0}};
      x_q       <= 32'd0;
      y_q       <= 32'd0;
      m_q       <= 32'd0;
      valid_q   <= {NUM_TOWNS{1'b0}};
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_addr_q <= rd_addr_d;
      index_q   <= index_d;
      x_q       <= x_d;
      y_q       <= y_d;
      m_q       <= m_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_visitor_x_pos          = x_q;
  assign o_visitor_y_pos          = y_q;
  assign o_visitor_mass           = m_q;
  assign o_relative_visitor_valid = valid_q;
  assign o_relative_visitor_index = rel_index_of(index_q);
  assign o_last_visitor           = last_q;
  assign o_busy                   = busy_q;
  assign o_done                   = done_q;
  assign o_visitor_index          = index_q;

endmodule

// File: tb/tb_visitor_center.sv
// Directed bench for visitor_center: a per-cycle vector table plus hand-written
// sequences for mid-stream reset, blocked HPS writes and the town mapping.
module tb_visitor_center;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [11:0] i_number_of_visitors = 12'd0;
  logic [3:0]  i_next = 4'b0000;
  logic [11:0] i_vis_write_addr = 12'd0;
  logic        i_vis_we = 1'b0;
  logic [31:0] i_x_write_data = 32'd0, i_y_write_data = 32'd0, i_mass_write_data = 32'd0;
  logic [31:0] o_visitor_x_pos, o_visitor_y_pos, o_visitor_mass;
  logic [3:0]  o_relative_visitor_valid;
  logic [9:0]  o_relative_visitor_index;
  logic        o_last_visitor, o_busy, o_done;
  logic [11:0] o_visitor_index;

  int total = 0;
  int bad = 0;

  visitor_center dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_number_of_visitors(i_number_of_visitors), .i_next(i_next),
    .i_vis_write_addr(i_vis_write_addr), .i_vis_we(i_vis_we),
    .i_x_write_data(i_x_write_data), .i_y_write_data(i_y_write_data),
    .i_mass_write_data(i_mass_write_data),
    .o_visitor_x_pos(o_visitor_x_pos), .o_visitor_y_pos(o_visitor_y_pos),
    .o_visitor_mass(o_visitor_mass),
    .o_relative_visitor_valid(o_relative_visitor_valid),
    .o_relative_visitor_index(o_relative_visitor_index),
    .o_last_visitor(o_last_visitor), .o_busy(o_busy), .o_done(o_done),
    .o_visitor_index(o_visitor_index)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        start;
    logic [11:0] nvis;
    logic [3:0]  nxt;
    int          vis;
    logic [11:0] idx;
    logic [3:0]  valid;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkv(input logic s, input logic [11:0] n, input logic [3:0] nx,
                               input int vis, input logic [11:0] idx, input logic [3:0] v,
                               input logic l, input logic b, input logic d);
    mkv.start = s; mkv.nvis = n; mkv.nxt = nx; mkv.vis = vis; mkv.idx = idx;
    mkv.valid = v; mkv.last = l; mkv.busy = b; mkv.done = d;
  endfunction

  // Visitor i carries x=100+i, y=200+i, mass=300+i; vis<0 means the reset-time zeros.
  function automatic logic [31:0] xv(input int vis);
    xv = (vis < 0) ? 32'd0 : 32'd100 + 32'(vis);
  endfunction
  function automatic logic [31:0] yv(input int vis);
    yv = (vis < 0) ? 32'd0 : 32'd200 + 32'(vis);
  endfunction
  function automatic logic [31:0] mv(input int vis);
    mv = (vis < 0) ? 32'd0 : 32'd300 + 32'(vis);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic hps_write(input logic [11:0] a, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] m);
    i_vis_write_addr = a; i_x_write_data = x; i_y_write_data = y; i_mass_write_data = m;
    i_vis_we = 1'b1;
    tick();
    i_vis_we = 1'b0;
  endtask

  task automatic start_pass(input logic [11:0] n);
    i_number_of_visitors = n;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    bit found;

    vecs[0]  = mkv(1'b1, 12'd3, 4'hF, -1, 12'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mkv(1'b0, 12'd3, 4'hF,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mkv(1'b0, 12'd3, 4'hF,  1, 12'd1, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[3]  = mkv(1'b0, 12'd3, 4'hF,  2, 12'd2, 4'b0001, 1'b1, 1'b1, 1'b0);
    vecs[4]  = mkv(1'b0, 12'd3, 4'hF,  2, 12'd2, 4'b0000, 1'b0, 1'b0, 1'b1);
    vecs[5]  = mkv(1'b0, 12'd3, 4'hF,  2, 12'd2, 4'b0000, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mkv(1'b1, 12'd2, 4'hF,  2, 12'd2, 4'b0000, 1'b0, 1'b1, 1'b0);
    vecs[7]  = mkv(1'b0, 12'd2, 4'h7,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mkv(1'b0, 12'd2, 4'h7,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mkv(1'b1, 12'd0, 4'h7,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[10] = mkv(1'b0, 12'd2, 4'h7,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[11] = mkv(1'b0, 12'd2, 4'h7,  0, 12'd0, 4'b0001, 1'b0, 1'b1, 1'b0);
    vecs[12] = mkv(1'b0, 12'd2, 4'hF,  1, 12'd1, 4'b0001, 1'b1, 1'b1, 1'b0);
    vecs[13] = mkv(1'b0, 12'd2, 4'h7,  1, 12'd1, 4'b0001, 1'b1, 1'b1, 1'b0);
    vecs[14] = mkv(1'b0, 12'd2, 4'hF,  1, 12'd1, 4'b0000, 1'b0, 1'b0, 1'b1);
    vecs[15] = mkv(1'b0, 12'd2, 4'hF,  1, 12'd1, 4'b0000, 1'b0, 1'b0, 1'b1);
    vecs[16] = mkv(1'b1, 12'd0, 4'hF,  1, 12'd1, 4'b0000, 1'b0, 1'b0, 1'b1);
    vecs[17] = mkv(1'b0, 12'd0, 4'hF,  1, 12'd1, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Reset state
    #12;
    chk("rst_x", o_visitor_x_pos, 32'd0);
    chk("rst_idx", o_visitor_index, 12'd0);
    chk("rst_valid", o_relative_visitor_valid, 4'b0000);
    chk("rst_flags", {o_last_visitor, o_busy, o_done}, 3'b000);
    @(negedge i_clk);
    i_rst = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) begin
      hps_write(12'(i), xv(i), yv(i), mv(i));
    end
    hps_write(12'd1029, 32'hC0DE_0405, 32'hC0DE_0406, 32'hC0DE_0407);

    // Table-driven stream: N=3 free-running, N=2 with stalls, N=0 from DONE
    for (int r = 0; r < 18; r++) begin
      i_start = vecs[r].start;
      i_number_of_visitors = vecs[r].nvis;
      i_next = vecs[r].nxt;
      tick();
      chk($sformatf("v%0d_x", r), o_visitor_x_pos, xv(vecs[r].vis));
      chk($sformatf("v%0d_y", r), o_visitor_y_pos, yv(vecs[r].vis));
      chk($sformatf("v%0d_m", r), o_visitor_mass, mv(vecs[r].vis));
      chk($sformatf("v%0d_idx", r), o_visitor_index, vecs[r].idx);
      chk($sformatf("v%0d_valid", r), o_relative_visitor_valid, vecs[r].valid);
      chk($sformatf("v%0d_flags", r), {o_last_visitor, o_busy, o_done},
          {vecs[r].last, vecs[r].busy, vecs[r].done});
    end
    i_start = 1'b0;
    i_next = 4'hF;

    // HPS write during PRIME/STREAM must be dropped
    start_pass(12'd3);
    i_vis_write_addr = 12'd0; i_x_write_data = 32'hDEAD;
    i_y_write_data = 32'hDEAD; i_mass_write_data = 32'hDEAD;
    i_vis_we = 1'b1;
    tick();
    tick();
    i_vis_we = 1'b0;
    tick();
    tick();
    chk("we_blk_done", o_done, 1'b1);
    start_pass(12'd1);
    tick();
    chk("we_blk_x0", o_visitor_x_pos, 32'd100);
    chk("we_blk_y0", o_visitor_y_pos, 32'd200);
    chk("n1_last", {o_last_visitor, o_busy}, 2'b11);
    tick();
    chk("n1_done", {o_done, o_busy, o_last_visitor}, 3'b100);

    // Reset mid-stream, then N=0 from IDLE, then table contents must survive
    start_pass(12'd3);
    tick();
    chk("mid_busy", o_busy, 1'b1);
    i_rst = 1'b0;
    #1;
    chk("mid_rst_x", o_visitor_x_pos, 32'd0);
    chk("mid_rst_idx", o_visitor_index, 12'd0);
    chk("mid_rst_outs", {o_relative_visitor_valid, o_last_visitor, o_busy, o_done}, 7'd0);
    tick();
    i_rst = 1'b1;
    tick();
    start_pass(12'd0);
    chk("n0_done", {o_done, o_busy}, 2'b10);
    chk("n0_valid", o_relative_visitor_valid, 4'b0000);
    start_pass(12'd3);
    for (int v = 0; v < 3; v++) begin
      tick();
      chk($sformatf("keep_x%0d", v), o_visitor_x_pos, xv(v));
      chk($sformatf("keep_m%0d", v), o_visitor_mass, mv(v));
    end
    tick();
    chk("keep_done", o_done, 1'b1);

    // Town mapping at index 1029: town 1, relative index 5, also the last visitor
    found = 1'b0;
    start_pass(12'd1030);
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (o_busy && (o_visitor_index == 12'd1029)) begin
        found = 1'b1;
        break;
      end
    end
    chk("t1029_found", found, 1'b1);
    chk("t1029_valid", o_relative_visitor_valid, 4'b0010);
    chk("t1029_rel", o_relative_visitor_index, 10'd5);
    chk("t1029_x", o_visitor_x_pos, 32'hC0DE_0405);
    chk("t1029_last", o_last_visitor, 1'b1);
    tick();
    chk("t1029_done", {o_done, o_relative_visitor_valid}, 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
